// File: rtl/led_matrix_spi_receiver.sv
// led_matrix_spi_receiver: SPI target that oversamples sclk/mosi/n_cs and turns
// received bytes into addressed frame-buffer pixel writes or an index-reset command.
module led_matrix_spi_receiver #(
    parameter int          SYNC_STAGES           = 2,
    parameter logic [7:0]  CMD_RESET_FRAME_INDEX = 8'h26,
    parameter logic [5:0]  PIXEL_MAX             = 6'h3f
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       n_cs,
    output logic       pix_valid,
    output logic [5:0] pix_addr,
    output logic [7:0] pix_data,
    output logic       cmd_valid,
    output logic       frame_done,
    output logic       abort
);
    typedef enum logic [1:0] {IDLE, FIRST, PIXELS, DISCARD} state_t;

    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic [SYNC_STAGES:0]   settle_q, settle_d;
    logic                   sclk_prev_q, ncs_prev_q, armed_q, armed_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [5:0]             idx_q, idx_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [5:0]             pix_addr_q, pix_addr_d;
    logic [7:0]             pix_data_q, pix_data_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   abort_q, abort_d;
    logic                   sclk_s, mosi_s, ncs_s;
    logic                   active, bit_edge, byte_done, is_cmd, emit, ncs_fall, ncs_rise;
    logic [7:0]             byte_val;

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ncs_sync_d   = {ncs_sync_q[SYNC_STAGES-2:0], n_cs};
        settle_d     = {settle_q[SYNC_STAGES-1:0], 1'b1};
        sclk_s       = sclk_sync_q[SYNC_STAGES-1];
        mosi_s       = mosi_sync_q[SYNC_STAGES-1];
        ncs_s        = ncs_sync_q[SYNC_STAGES-1];
        // A fall is only trusted once n_cs has been seen high after the pipeline flushed
        armed_d      = armed_q | (settle_q[SYNC_STAGES] & ncs_s);
        ncs_fall     = armed_q & ncs_prev_q & ~ncs_s;
        ncs_rise     = ncs_s & ~ncs_prev_q;
        active       = state_q != IDLE;
        bit_edge     = active & sclk_s & ~sclk_prev_q;
        byte_val     = {shift_q[6:0], mosi_s};
        byte_done    = bit_edge & (bit_cnt_q == 3'd7);
        is_cmd       = byte_done & (state_q == FIRST) & (byte_val == CMD_RESET_FRAME_INDEX);
        emit         = byte_done & (state_q != DISCARD) & ~is_cmd;
        shift_d      = bit_edge ? byte_val : shift_q;
        bit_cnt_d    = bit_edge ? bit_cnt_q + 3'd1 : bit_cnt_q;
        pix_valid_d  = emit;
        pix_addr_d   = emit ? idx_q : pix_addr_q;
        pix_data_d   = emit ? byte_val : pix_data_q;
        frame_done_d = emit & (idx_q == PIXEL_MAX);
        cmd_valid_d  = is_cmd;
        idx_d        = is_cmd ? 6'd0 : emit ? ((idx_q == PIXEL_MAX) ? 6'd0 : idx_q + 6'd1) : idx_q;
        abort_d      = active & ncs_rise & (bit_cnt_d != 3'd0);
        state_d      = state_q;
        case (state_q)
            IDLE:    state_d = ncs_fall ? FIRST : IDLE;
            FIRST:   state_d = byte_done ? (is_cmd ? DISCARD : PIXELS) : FIRST;
            default: state_d = state_q;
        endcase
        if (active && ncs_rise) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            ncs_sync_q   <= '1;
            settle_q     <= '0;
            sclk_prev_q  <= 1'b0;
            ncs_prev_q   <= 1'b1;
            armed_q      <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            idx_q        <= 6'd0;
            pix_valid_q  <= 1'b0;
            pix_addr_q   <= 6'd0;
            pix_data_q   <= 8'd0;
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            ncs_sync_q   <= ncs_sync_d;
            settle_q     <= settle_d;
            sclk_prev_q  <= sclk_s;
            ncs_prev_q   <= ncs_s;
            armed_q      <= armed_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            pix_valid_q  <= pix_valid_d;
            pix_addr_q   <= pix_addr_d;
            pix_data_q   <= pix_data_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_done_q <= frame_done_d;
            abort_q      <= abort_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_addr   = pix_addr_q;
    assign pix_data   = pix_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign frame_done = frame_done_q;
    assign abort      = abort_q;
endmodule

// File: tb/tb_led_matrix_spi_receiver.sv
// tb_led_matrix_spi_receiver: drives SPI windows, predicts pixel writes into a
// scoreboard queue and compares them against the strobes the receiver logs.
module tb_led_matrix_spi_receiver;
    logic       clock = 1'b0, reset_n = 1'b0, sclk = 1'b0, mosi = 1'b0, n_cs = 1'b1;
    logic       pix_valid, cmd_valid, frame_done, abort;
    logic [5:0] pix_addr;
    logic [7:0] pix_data;

    led_matrix_spi_receiver dut (
        .clock(clock), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .n_cs(n_cs),
        .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_data(pix_data),
        .cmd_valid(cmd_valid), .frame_done(frame_done), .abort(abort)
    );

    always #5 clock = ~clock;

    typedef struct {logic [5:0] a; logic [7:0] d; logic fd;} pix_t;

    int         vectors = 0, miscompares = 0;
    logic [5:0] obs_addr [0:511];
    logic [7:0] obs_data [0:511];
    logic       obs_fd   [0:511];
    int         obs_n = 0, cmd_cnt = 0, abort_cnt = 0, fd_cnt = 0;
    pix_t       exp_q[$];
    int         obs_rd = 0, model_idx = 0;
    bit         in_first = 1'b0, in_discard = 1'b0;

    always @(negedge clock) begin
        if (pix_valid && obs_n < 512) begin
            obs_addr[obs_n] = pix_addr;
            obs_data[obs_n] = pix_data;
            obs_fd[obs_n]   = frame_done;
            obs_n++;
        end
        if (cmd_valid)  cmd_cnt++;
        if (abort)      abort_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic spi_bit(input logic b);
        mosi = b;
        #40 sclk = 1'b1;
        #40 sclk = 1'b0;
    endtask

    task automatic window_begin();
        n_cs = 1'b0;
        #60;
        in_first   = 1'b1;
        in_discard = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        pix_t e;
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
        if (in_first && b == 8'h26) begin
            model_idx  = 0;
            in_discard = 1'b1;
        end else if (!in_discard) begin
            e.a = model_idx[5:0];
            e.d = b;
            e.fd = (model_idx == 63);
            exp_q.push_back(e);
            model_idx = (model_idx + 1) % 64;
        end
        in_first = 1'b0;
    endtask

    task automatic window_end();
        #60 n_cs = 1'b1;
        #200;
    endtask

    task automatic scoreboard_drain(input string name);
        pix_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_rd >= obs_n) begin
                miscompares++;
                $display("FAIL %s: missing pixel, expected addr=%0d data=%02h", name, e.a, e.d);
            end else begin
                if (obs_addr[obs_rd] !== e.a || obs_data[obs_rd] !== e.d || obs_fd[obs_rd] !== e.fd) begin
                    miscompares++;
                    $display("FAIL %s: pixel got addr=%0d data=%02h fd=%0b, expected addr=%0d data=%02h fd=%0b",
                             name, obs_addr[obs_rd], obs_data[obs_rd], obs_fd[obs_rd], e.a, e.d, e.fd);
                end
                obs_rd++;
            end
        end
        vectors++;
        if (obs_rd != obs_n) begin
            miscompares++;
            $display("FAIL %s: %0d unexpected extra pixels, expected 0", name, obs_n - obs_rd);
        end
        obs_rd = obs_n;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #23 reset_n = 1'b1;
        #100;
        model_idx = 0;
        exp_q.delete();
        obs_rd = obs_n;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({pix_valid, pix_addr, pix_data, cmd_valid, frame_done, abort} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_state: outputs %b, expected all zero",
                     {pix_valid, pix_addr, pix_data, cmd_valid, frame_done, abort});
        end
        reset_n = 1'b1;
        #100;
    endtask

    task automatic test_frame();
        int c0 = cmd_cnt, f0 = fd_cnt;
        window_begin(); send_byte(8'h26); window_end();
        window_begin();
        for (int i = 0; i < 64; i++) send_byte(8'(i));
        window_end();
        scoreboard_drain("frame");
        vectors++;
        if (cmd_cnt - c0 != 1) begin
            miscompares++;
            $display("FAIL frame_cmd: cmd_valid pulses %0d, expected 1", cmd_cnt - c0);
        end
        vectors++;
        if (fd_cnt - f0 != 1) begin
            miscompares++;
            $display("FAIL frame_done_count: pulses %0d, expected 1", fd_cnt - f0);
        end
    endtask

    task automatic test_command_position();
        int c0 = cmd_cnt;
        window_begin(); send_byte(8'h11); send_byte(8'h26); window_end();
        scoreboard_drain("cmd_position");
        vectors++;
        if (cmd_cnt != c0) begin
            miscompares++;
            $display("FAIL cmd_position_cmd: cmd_valid pulses %0d, expected 0", cmd_cnt - c0);
        end
    endtask

    task automatic test_discard();
        int c0 = cmd_cnt;
        window_begin(); send_byte(8'h26); send_byte(8'hFF); send_byte(8'hFF); window_end();
        scoreboard_drain("discard");
        vectors++;
        if (cmd_cnt - c0 != 1) begin
            miscompares++;
            $display("FAIL discard_cmd: cmd_valid pulses %0d, expected 1", cmd_cnt - c0);
        end
        window_begin(); send_byte(8'h5A); window_end();
        scoreboard_drain("discard_index");
    endtask

    task automatic test_abort();
        int a0 = abort_cnt;
        logic [7:0] b = 8'hC3;
        window_begin();
        for (int i = 7; i >= 3; i--) spi_bit(b[i]);
        window_end();
        vectors++;
        if (abort_cnt - a0 != 1) begin
            miscompares++;
            $display("FAIL abort_count: abort pulses %0d, expected 1", abort_cnt - a0);
        end
        scoreboard_drain("abort_partial");
        window_begin(); send_byte(8'h12); window_end();
        scoreboard_drain("abort_next");
    endtask

    task automatic test_wrap();
        int f0;
        do_reset();
        f0 = fd_cnt;
        window_begin();
        for (int i = 0; i < 65; i++) send_byte(8'hA5);
        window_end();
        scoreboard_drain("wrap");
        vectors++;
        if (fd_cnt - f0 != 1) begin
            miscompares++;
            $display("FAIL wrap_frame_done: pulses %0d, expected 1", fd_cnt - f0);
        end
    endtask

    task automatic test_reset_mid();
        int c0, a0, f0;
        logic [7:0] b = 8'h9C;
        window_begin(); send_byte(8'h33); window_end();
        scoreboard_drain("reset_pre");
        c0 = cmd_cnt; a0 = abort_cnt; f0 = fd_cnt;
        window_begin();
        for (int i = 7; i >= 4; i--) spi_bit(b[i]);
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({pix_valid, pix_addr, pix_data, cmd_valid, frame_done, abort} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: outputs %b, expected all zero",
                     {pix_valid, pix_addr, pix_data, cmd_valid, frame_done, abort});
        end
        #30 reset_n = 1'b1;
        for (int i = 3; i >= 0; i--) spi_bit(b[i]);
        model_idx = 0;
        window_end();
        vectors++;
        if (cmd_cnt != c0 || abort_cnt != a0 || fd_cnt != f0 || obs_n != obs_rd) begin
            miscompares++;
            $display("FAIL reset_mid_strobes: cmd=%0d abort=%0d fd=%0d pix=%0d, expected all 0",
                     cmd_cnt - c0, abort_cnt - a0, fd_cnt - f0, obs_n - obs_rd);
        end
        window_begin(); send_byte(8'h44); window_end();
        scoreboard_drain("reset_after");
    endtask

    initial begin
        test_reset();
        test_frame();
        test_command_position();
        test_discard();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/led_matrix_spi_receiver.md
# led_matrix_spi_receiver

Receiver end of the LED-matrix SPI link: the SPI-target (slave) side that the matrix driver's SPI master talks to. It oversamples `sclk`/`mosi`/`n_cs` in its own clock domain, assembles MSB-first bytes, and decodes the frame-index-reset command (0x26). It turns pixel bytes into addressed write strobes for a 64-entry frame buffer, giving the team an on-chip loopback and a model of the matrix for verifying the driver.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronisers, applied identically to `sclk`, `mosi` and `n_cs`. Minimum 2.
- `CMD_RESET_FRAME_INDEX`, default 8'h26: command byte that resets the pixel index.
- `PIXEL_MAX`, default 6'h3f: last pixel address. The address space is 6 bits.

Ports:
- `clock`  in  1: system clock. Must run ≥4× the `sclk` frequency.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sclk`  in  1: SPI clock, async to `clock`, idle low. Data is sampled on its rising edge.
- `mosi`  in  1: SPI data, MSB first.
- `n_cs`  in  1: chip select, active low.
- `pix_valid`  out  1: one-cycle strobe; a pixel byte was received.
- `pix_addr`  out  6: frame-buffer address of the current pixel. Valid when `pix_valid` is high.
- `pix_data`  out  8: pixel byte, packed {R[2:0],G[2:0],B[1:0]}. Valid when `pix_valid` is high.
- `cmd_valid`  out  1: one-cycle strobe; frame-index-reset command accepted.
- `frame_done`  out  1: one-cycle strobe, coincident with the `pix_valid` that writes address `PIXEL_MAX`.
- `abort`  out  1: one-cycle strobe; `n_cs` deasserted with a partial byte pending.

## Operation
- Input path: a `SYNC_STAGES` synchroniser on each input.
  - Synchroniser reset values: `sclk` 0, `mosi` 0, `n_cs` 1.
  - One extra register per line provides edge detection.
  - `sclk` rise = synchronised `sclk` is 1 and the previous value was 0.
  - `mosi` is taken from the same pipeline stage as `sclk`, so the two stay aligned.
- Transaction states:
  - IDLE (`n_cs` high): bit counter = 0, first-byte flag = 1.
  - On a synchronised `n_cs` fall → FIRST.
  - FIRST: shift `mosi` in on each `sclk` rise, MSB first. After the 8th bit:
    - byte == `CMD_RESET_FRAME_INDEX` → pixel index ← 0, pulse `cmd_valid`, → DISCARD.
    - otherwise → emit it as a pixel, → PIXELS.
  - PIXELS: every completed byte is a pixel, including a byte equal to 0x26.
  - DISCARD: bytes are shifted in but produce no output until `n_cs` rises.
  - A synchronised `n_cs` rise in any state → IDLE.
    - Bit counter ≠ 0 at that point → pulse `abort` and drop the partial byte.
    - The pixel index is retained.
- Pixel emit:
  - `pix_addr` ← pixel index, `pix_data` ← byte, pulse `pix_valid`.
  - Then pixel index ← index+1, wrapping `PIXEL_MAX`→0 (6-bit modulo).
  - `frame_done` pulses when the emitted address == `PIXEL_MAX`.
- `sclk` edges while `n_cs` is (synchronised) high are ignored.
- The bit counter is 3 bits and wraps 7→0 on byte completion.

## Timing
- Reset (async assert, sync to `clock` deassert inside the block): all strobes 0, `pix_addr` 0, `pix_data` 0, pixel index 0, state IDLE.
- Latency: a pin-level `sclk` rise registers as an edge after `SYNC_STAGES`+1 `clock` edges.
- Byte-completion outputs appear one cycle after the 8th edge is detected:
  - strobes (`pix_valid`/`cmd_valid`/`frame_done`) are high for exactly one cycle;
  - `pix_addr`/`pix_data` hold their value until the next emit.
- Simultaneous 8th-bit edge and `n_cs` rise in the same cycle: the byte completes and is emitted; no `abort`.
- `reset_n` low mid-transaction: all state clears immediately and no strobe is produced. After release, the block waits for a fresh `n_cs` fall; if `n_cs` is already low, it waits for high, then low.
- Throughput: one byte per 8 `sclk` periods. Back-to-back bytes with `n_cs` held low must lose nothing.

## Test plan
- Frame: command 0x26 in its own CS window, then 64 bytes 0x00..0x3F in one CS window.
  - `cmd_valid` pulses ×1.
  - 64 `pix_valid` pulses, addresses 0..63, data equal to address.
  - `frame_done` pulses only with address 63.
- Wrap: after reset, 65 pixel bytes 0xA5 in one window → the 65th emits `pix_addr`=0 and there are no extra `frame_done` pulses.
- Command position: window containing 0x11, 0x26 → two pixels, with addresses 0 and 1 and data 0x11 and 0x26; no `cmd_valid`.
- Discard: window containing 0x26, 0xFF, 0xFF → `cmd_valid` ×1, zero `pix_valid`, pixel index 0.
- Abort: 5 bits of 0xC3, then `n_cs` rises → `abort` ×1, no `pix_valid`. The next window's byte 0x12 lands at the unchanged index.
- Reset: `reset_n` pulsed low after 4 bits of a byte → all outputs 0, no strobes. The next clean window emits its first pixel at address 0.
